// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand/result widths, opcode map and result-FIFO entry layout.
package alu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;
    localparam int RES_W  = 9;
    localparam int TAG_W  = 4;
    localparam int FIFO_W = RES_W + TAG_W + 1;

    localparam logic [OP_W-1:0] OP_NOP   = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0011;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0100;
    localparam logic [OP_W-1:0] OP_XOR   = 4'b0101;
    localparam logic [OP_W-1:0] OP_SHL   = 4'b0110;
    localparam logic [OP_W-1:0] OP_SHR   = 4'b0111;
    localparam logic [OP_W-1:0] OP_NOT   = 4'b1000;
    localparam logic [OP_W-1:0] OP_PASSA = 4'b1001;
    localparam logic [OP_W-1:0] OP_MAX   = 4'b1010;

    typedef enum logic [0:0] {StIdle, StExec} seq_state_e;

    typedef struct packed {
        logic [RES_W-1:0] data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } res_entry_t;

    function automatic logic op_legal(input logic [OP_W-1:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// First-word fall-through result FIFO; Depth must be a power of two so pointers wrap naturally.
module alu_res_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [Width-1:0] push_data,
    input  logic             pop,
    output logic [Width-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty     = (count_q == '0);
    assign full      = (count_q == CntW'(Depth));
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Two-cycle command sequencer for an external combinational ALU with a buffered result queue.
// Optional accumulator operand enabled by defining ALU_CMD_SEQ_ACC_MODE_EN.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [TAG_W-1:0]  cmd_tag,
    input  logic              cmd_acc,
    output logic [OP_W-1:0]   alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [RES_W-1:0]  alu_res,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [RES_W-1:0]  res_data,
    output logic [TAG_W-1:0]  res_tag,
    output logic              res_err,
    output logic              busy
);

    seq_state_e        state_q, state_d;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] op_a;
    logic              accept, push;
    logic              fifo_full, fifo_empty;
    res_entry_t        push_entry, head_entry;

    assign cmd_ready = !rst && (state_q == StIdle) && !fifo_full;

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        push    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                push    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            alu_op  <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_op <= cmd_op;
                alu_a  <= op_a;
                alu_b  <= cmd_b;
                tag_q  <= cmd_tag;
            end
        end
    end

    // Illegal opcodes report an error with a zeroed payload regardless of what the ALU returns.
    always_comb begin
        push_entry.err  = !op_legal(alu_op);
        push_entry.data = push_entry.err ? '0 : alu_res;
        push_entry.tag  = tag_q;
    end

`ifdef ALU_CMD_SEQ_ACC_MODE_EN
    logic [DATA_W-1:0] acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else if (push && !push_entry.err) begin
            acc_q <= alu_res[DATA_W-1:0];
        end
    end

    assign op_a = cmd_acc ? acc_q : cmd_a;
`else
    logic unused_cmd_acc;
    assign unused_cmd_acc = cmd_acc;
    assign op_a           = cmd_a;
`endif

    alu_res_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (FIFO_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (res_valid && res_ready),
        .head_data (head_entry),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign res_valid = !fifo_empty;
    assign res_data  = head_entry.data;
    assign res_tag   = head_entry.tag;
    assign res_err   = head_entry.err;
    assign busy      = (state_q == StExec) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed self-checking bench for alu_cmd_seq with a behavioural model of the external ALU.
module tb_alu_cmd_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready, cmd_acc;
    logic [3:0] cmd_op, cmd_tag;
    logic [7:0] cmd_a, cmd_b;
    logic [3:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [8:0] alu_res;
    logic       res_valid, res_ready, res_err, busy;
    logic [8:0] res_data;
    logic [3:0] res_tag;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_seq #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_tag   (cmd_tag),
        .cmd_acc   (cmd_acc),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_res   (alu_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_tag   (res_tag),
        .res_err   (res_err),
        .busy      (busy)
    );

    // External ALU; illegal opcodes return all-ones so payload forcing is observable.
    always_comb begin
        case (alu_op)
            4'h0:    alu_res = 9'h000;
            4'h1:    alu_res = {1'b0, alu_a} + {1'b0, alu_b};
            4'h2:    alu_res = {1'b0, alu_a} - {1'b0, alu_b};
            4'h3:    alu_res = {1'b0, alu_a & alu_b};
            4'h4:    alu_res = {1'b0, alu_a | alu_b};
            4'h5:    alu_res = {1'b0, alu_a ^ alu_b};
            4'h6:    alu_res = {alu_a, 1'b0};
            4'h7:    alu_res = {2'b00, alu_a[7:1]};
            4'h8:    alu_res = {1'b0, ~alu_a};
            4'h9:    alu_res = {1'b0, alu_a};
            4'hA:    alu_res = {1'b0, alu_b};
            default: alu_res = 9'h1FF;
        endcase
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] tag;
        logic [8:0] data;
        logic       err;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Offers a command and returns #1 after the accepting edge.
    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] tag, input logic acc);
        int n = 0;
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag; cmd_acc = acc;
        cmd_valid = 1'b1;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got cmd_ready=0 expected 1 within 20 cycles");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_acc   = 1'b0;
    endtask

    task automatic pop_one();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        send(v.op, v.a, v.b, v.tag, 1'b0);
        chk("valid_after_1_edge", res_valid, 1'b0);
        chk("busy_in_exec", busy, 1'b1);
        @(posedge clk);
        #1;
        chk("valid_after_2_edges", res_valid, 1'b1);
        chk("res_data", res_data, v.data);
        chk("res_tag", res_tag, v.tag);
        chk("res_err", res_err, v.err);
        pop_one();
        chk("valid_after_pop", res_valid, 1'b0);
        chk("busy_after_pop", busy, 1'b0);
        chk("alu_a_hold", alu_a, v.a);
        chk("alu_op_hold", alu_op, v.op);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{op: 4'h1, a: 8'h6B, b: 8'hAA, tag: 4'h3, data: 9'h115, err: 1'b0};
        vecs[1] = '{op: 4'h2, a: 8'h6B, b: 8'hAA, tag: 4'h4, data: 9'h1C1, err: 1'b0};
        vecs[2] = '{op: 4'hA, a: 8'h6B, b: 8'hAA, tag: 4'h5, data: 9'h0AA, err: 1'b0};
        vecs[3] = '{op: 4'hF, a: 8'hFF, b: 8'hFF, tag: 4'h6, data: 9'h000, err: 1'b1};
        vecs[4] = '{op: 4'hB, a: 8'h12, b: 8'h34, tag: 4'h7, data: 9'h000, err: 1'b1};
        vecs[5] = '{op: 4'h3, a: 8'hF0, b: 8'h3C, tag: 4'h8, data: 9'h030, err: 1'b0};
        vecs[6] = '{op: 4'h0, a: 8'h55, b: 8'h66, tag: 4'h9, data: 9'h000, err: 1'b0};
        vecs[7] = '{op: 4'h5, a: 8'h0F, b: 8'hFF, tag: 4'hA, data: 9'h0F0, err: 1'b0};
        vecs[8] = '{op: 4'h6, a: 8'h81, b: 8'h00, tag: 4'hB, data: 9'h102, err: 1'b0};

        rst = 1'b1; cmd_valid = 1'b0; cmd_acc = 1'b0; res_ready = 1'b0;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("cmd_ready_in_reset", cmd_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reset_res_valid", res_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_cmd_ready", cmd_ready, 1'b1);
        chk("reset_alu_op", alu_op, 4'h0);
        chk("reset_alu_a", alu_a, 8'h00);
        chk("reset_alu_b", alu_b, 8'h00);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Reset while a command is executing must drop it.
        send(4'h1, 8'h11, 8'h22, 4'h2, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midexec_res_valid", res_valid, 1'b0);
        chk("midexec_busy", busy, 1'b0);
        chk("midexec_alu_a", alu_a, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("midexec_no_late_push", res_valid, 1'b0);

        // Fill the queue with no consumer, then free one slot for the fifth command.
        for (int k = 1; k <= 4; k++) send(4'h1, 8'(k * 16), 8'h01, 4'(k), 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        cmd_op = 4'h1; cmd_a = 8'h50; cmd_b = 8'h01; cmd_tag = 4'h5; cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("full_cmd_ready_low", cmd_ready, 1'b0);
            @(negedge clk);
        end
        chk("full_head_tag", res_tag, 4'h1);
        chk("full_head_data", res_data, 9'h011);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        chk("after_pop_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk("drain_valid", res_valid, 1'b1);
            chk("drain_tag", res_tag, 4'(k));
            chk("drain_data", res_data, 9'(k * 16 + 1));
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
        end
        chk("drain_empty", res_valid, 1'b0);
        chk("drain_busy", busy, 1'b0);

`ifdef ALU_CMD_SEQ_ACC_MODE_EN
        send(4'h1, 8'h01, 8'h02, 4'hC, 1'b0);
        @(posedge clk);
        #1;
        chk("acc_first", res_data, 9'h003);
        pop_one();
        send(4'h1, 8'h77, 8'h05, 4'hD, 1'b1);
        @(posedge clk);
        #1;
        chk("acc_second", res_data, 9'h008);
        chk("acc_tag", res_tag, 4'hD);
        pop_one();
`else
        send(4'h1, 8'h10, 8'h05, 4'hC, 1'b1);
        @(posedge clk);
        #1;
        chk("acc_ignored", res_data, 9'h015);
        chk("acc_ignored_tag", res_tag, 4'hC);
        pop_one();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
